// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory-address mux selector codes, exception cause
// codes and the exception vector addresses the memory decodes them to.
package cpu_defs;

  // Memory-address mux selector codes
  localparam logic [3:0] SEL_PC   = 4'b0000;
  localparam logic [3:0] SEL_ALU  = 4'b0001;
  localparam logic [3:0] SEL_OPC  = 4'b0010;
  localparam logic [3:0] SEL_OVF  = 4'b0011;
  localparam logic [3:0] SEL_DIV0 = 4'b0100;
  localparam logic [3:0] SEL_RS   = 4'b0101;

  // Exception cause codes, as reported on exc_cause
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OPC  = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIV0 = 2'd3
  } cause_e;

  // Handler-byte addresses selected by the vector selector codes
  localparam logic [7:0] VEC_ADDR_OPC  = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVF  = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIV0 = 8'd255;

  // Selector code that points the memory at the vector for a given cause
  function automatic logic [3:0] vector_sel(input cause_e cause);
    case (cause)
      CAUSE_OPC:  return SEL_OPC;
      CAUSE_OVF:  return SEL_OVF;
      CAUSE_DIV0: return SEL_DIV0;
      default:    return SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exc_cause_encoder.sv
// Priority encoder for the three exception request lines.
// Priority opcode > overflow > div0; lower simultaneous requests are dropped.
module exc_cause_encoder
  import cpu_defs::*;
(
  input  logic       req_opcode_i,
  input  logic       req_overflow_i,
  input  logic       req_div0_i,
  output logic       valid_o,
  output cause_e     cause_o,
  output logic [3:0] sel_o
);

  // Pick the highest-priority request and its vector selector
  always_comb begin
    valid_o = 1'b0;
    cause_o = CAUSE_NONE;
    if (req_opcode_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_OPC;
    end else if (req_overflow_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_OVF;
    end else if (req_div0_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_DIV0;
    end
    sel_o = vector_sel(cause_o);
  end

endmodule

// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer for the memory-address mux.
// IDLE passes the main control's selector through. An accepted request
// latches cause and EPC, then SAVE (EPC write) -> WAIT (MEM_WAIT cycles of
// memory latency on the vector address) -> LOAD (PC write from handler byte).
// Requests are only sampled in IDLE; anything arriving while busy is dropped.
// MEM_WAIT must be >= 1.
module exc_sequencer
  import cpu_defs::*;
#(
  parameter int          MEM_WAIT  = 2,
  parameter logic [31:0] PC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl_mux_sel,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mux_sel,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic        stall,
  output logic [1:0]  exc_cause,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cause_e           cause_q, cause_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      epc_q, epc_d;

  logic             enc_valid;
  cause_e           enc_cause;
  logic [3:0]       enc_sel;

  // Only the handler byte is used; the upper read-data bits are ignored
  logic             unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  exc_cause_encoder u_enc (
    .req_opcode_i   (exc_opcode),
    .req_overflow_i (exc_overflow),
    .req_div0_i     (exc_div0),
    .valid_o        (enc_valid),
    .cause_o        (enc_cause),
    .sel_o          (enc_sel)
  );

  // State and datapath registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      sel_q   <= SEL_PC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      sel_q   <= sel_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state logic: accept in IDLE only, count memory latency in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    sel_d   = sel_q;
    epc_d   = epc_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = SAVE;
          cause_d = enc_cause;
          sel_d   = enc_sel;
          epc_d   = pc_in - PC_OFFSET;
        end
      end
      SAVE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: the sequencer owns the mux selector whenever busy
  always_comb begin
    mux_sel = ctrl_mux_sel;
    epc_wr  = 1'b0;
    pc_wr   = 1'b0;
    done    = 1'b0;
    stall   = (state_q != IDLE);
    if (state_q != IDLE) begin
      mux_sel = sel_q;
    end
    if (state_q == SAVE) begin
      epc_wr = 1'b1;
    end
    if (state_q == LOAD) begin
      pc_wr = 1'b1;
      done  = 1'b1;
    end
  end

  assign pc_data   = {24'h0, mem_rdata[7:0]};
  assign epc_data  = epc_q;
  assign exc_cause = cause_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: two instances (MEM_WAIT=2 default, MEM_WAIT=1)
// share stimulus and are compared every cycle against a timeline model that
// counts cycles since an accepted request. Directed scenarios pin literal
// values, then randomized requests/reset run against the model.
module tb_exc_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  ctrl_mux_sel;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in, mem_rdata;

  logic [3:0]  mux_sel   [2];
  logic        epc_wr    [2];
  logic [31:0] epc_data  [2];
  logic        pc_wr     [2];
  logic [31:0] pc_data   [2];
  logic        stall     [2];
  logic [1:0]  exc_cause [2];
  logic        done      [2];
  logic [1:0]  dbg_state [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  exc_sequencer #(.MEM_WAIT(2)) dut0 (
    .clk(clk), .reset(reset), .ctrl_mux_sel(ctrl_mux_sel),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .mux_sel(mux_sel[0]), .epc_wr(epc_wr[0]), .epc_data(epc_data[0]),
    .pc_wr(pc_wr[0]), .pc_data(pc_data[0]), .stall(stall[0]),
    .exc_cause(exc_cause[0]), .done(done[0]), .dbg_state(dbg_state[0])
  );

  exc_sequencer #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .ctrl_mux_sel(ctrl_mux_sel),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .mux_sel(mux_sel[1]), .epc_wr(epc_wr[1]), .epc_data(epc_data[1]),
    .pc_wr(pc_wr[1]), .pc_data(pc_data[1]), .stall(stall[1]),
    .exc_cause(exc_cause[1]), .done(done[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph = cycles since the accepted request (0 = idle). SAVE is ph 1,
  // PC write happens at ph 2+MEM_WAIT, then the sequencer is idle again.
  int          mw   [2] = '{2, 1};
  int          ph   [2];
  logic [1:0]  m_cause [2];
  logic [31:0] m_epc   [2];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        ph[i] = 0;
        m_cause[i] = 2'd0;
        m_epc[i] = 32'h0;
      end else if (ph[i] == 0) begin
        if (exc_opcode || exc_overflow || exc_div0) begin
          ph[i] = 1;
          m_cause[i] = exc_opcode ? 2'd1 : (exc_overflow ? 2'd2 : 2'd3);
          m_epc[i] = pc_in - 32'd4;
        end
      end else if (ph[i] == mw[i] + 2) begin
        ph[i] = 0;
      end else begin
        ph[i] = ph[i] + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      logic exp_busy, exp_save, exp_load;
      logic [3:0] exp_sel;
      exp_busy = (ph[i] != 0);
      exp_save = (ph[i] == 1);
      exp_load = (ph[i] == mw[i] + 2);
      // vector selector codes are cause + 1 (opc 2, ovf 3, div0 4)
      exp_sel  = exp_busy ? 4'(m_cause[i] + 2'd0) + 4'd1 : ctrl_mux_sel;
      chk($sformatf("u%0d stall", i), 32'(stall[i]), 32'(exp_busy));
      chk($sformatf("u%0d mux_sel", i), 32'(mux_sel[i]), 32'(exp_sel));
      chk($sformatf("u%0d epc_wr", i), 32'(epc_wr[i]), 32'(exp_save));
      chk($sformatf("u%0d pc_wr", i), 32'(pc_wr[i]), 32'(exp_load));
      chk($sformatf("u%0d done", i), 32'(done[i]), 32'(exp_load));
      chk($sformatf("u%0d exc_cause", i), 32'(exc_cause[i]), 32'(m_cause[i]));
      chk($sformatf("u%0d epc_data", i), epc_data[i], m_epc[i]);
      if (exp_load)
        chk($sformatf("u%0d pc_data", i), pc_data[i], {24'h0, mem_rdata[7:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    exc_opcode = 1'b0;
    exc_overflow = 1'b0;
    exc_div0 = 1'b0;
  endtask

  task automatic settle(input int n);
    clear_reqs();
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int npc;
    logic seen;
    reset = 1'b0;
    ctrl_mux_sel = 4'b0101;
    pc_in = 32'h0;
    mem_rdata = 32'h0;
    clear_reqs();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset mux_sel", 32'(mux_sel[0]), 32'h5);
    chk("reset stall", 32'(stall[0]), 32'h0);
    chk("reset cause", 32'(exc_cause[0]), 32'h0);
    chk("reset epc_data", epc_data[0], 32'h0);
    @(negedge clk) reset = 1'b1;

    // Idle pass-through
    repeat (2) @(negedge clk);
    chk("idle mux_sel", 32'(mux_sel[0]), 32'h5);
    chk("idle stall", 32'(stall[0]), 32'h0);
    chk("idle epc_wr", 32'(epc_wr[0]), 32'h0);
    chk("idle pc_wr", 32'(pc_wr[0]), 32'h0);

    // Overflow at pc 0x40, handler byte 0xA7 (cycle 0 driven here)
    pc_in = 32'h40; mem_rdata = 32'h0000_00A7; exc_overflow = 1'b1;
    @(negedge clk);  // cycle 1
    chk("ovf c1 epc_wr", 32'(epc_wr[0]), 32'h1);
    chk("ovf c1 epc_data", epc_data[0], 32'h3C);
    chk("ovf c1 mux_sel", 32'(mux_sel[0]), 32'h3);
    chk("ovf c1 stall", 32'(stall[0]), 32'h1);
    chk("model epc", m_epc[0], 32'h3C);
    chk("model cause", 32'(m_cause[0]), 32'h2);
    exc_overflow = 1'b0;
    @(negedge clk);  // cycle 2
    @(negedge clk);  // cycle 3
    chk("mw1 c3 pc_wr", 32'(pc_wr[1]), 32'h1);
    chk("mw1 c3 pc_data", pc_data[1], 32'hA7);
    chk("ovf c3 pc_wr", 32'(pc_wr[0]), 32'h0);
    @(negedge clk);  // cycle 4
    chk("ovf c4 pc_wr", 32'(pc_wr[0]), 32'h1);
    chk("ovf c4 pc_data", pc_data[0], 32'hA7);
    chk("ovf c4 done", 32'(done[0]), 32'h1);
    chk("ovf c4 cause", 32'(exc_cause[0]), 32'h2);
    chk("mw1 c4 stall", 32'(stall[1]), 32'h0);
    @(negedge clk);  // cycle 5
    chk("ovf c5 stall", 32'(stall[0]), 32'h0);
    chk("ovf c5 mux_sel", 32'(mux_sel[0]), 32'h5);
    settle(2);

    // Priority: opcode and div0 together
    exc_opcode = 1'b1; exc_div0 = 1'b1;
    @(negedge clk);
    chk("prio mux_sel", 32'(mux_sel[0]), 32'h2);
    chk("prio cause", 32'(exc_cause[0]), 32'h1);
    settle(6);

    // Busy ignore: div0 pulses in cycles 2 and 4 of an opcode sequence
    npc = 0;
    exc_opcode = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exc_opcode = 1'b0;
      npc += int'(pc_wr[0]);
      if (c == 5) begin
        chk("busy c5 stall", 32'(stall[0]), 32'h0);
        chk("busy c5 cause", 32'(exc_cause[0]), 32'h1);
      end
      exc_div0 = (c == 2 || c == 4);
    end
    chk("busy pc_wr count", 32'(npc), 32'h1);
    settle(6);

    // pc_in = 0 wraps
    pc_in = 32'h0; exc_overflow = 1'b1;
    @(negedge clk);
    chk("wrap epc_data", epc_data[0], 32'hFFFF_FFFC);
    settle(6);

    // Back-to-back: new request first IDLE cycle after LOAD
    pc_in = 32'h100; mem_rdata = 32'h1234_5655; exc_overflow = 1'b1;
    @(negedge clk);  // c1
    exc_overflow = 1'b0;
    repeat (3) @(negedge clk);  // c4 LOAD
    chk("b2b c4 pc_data", pc_data[0], 32'h55);
    @(negedge clk);  // c5 IDLE
    exc_div0 = 1'b1;
    @(negedge clk);  // c6 SAVE
    chk("b2b c6 epc_wr", 32'(epc_wr[0]), 32'h1);
    chk("b2b c6 mux_sel", 32'(mux_sel[0]), 32'h4);
    chk("b2b c6 cause", 32'(exc_cause[0]), 32'h3);
    settle(6);

    // Reset mid-WAIT
    ctrl_mux_sel = 4'b0001;
    exc_opcode = 1'b1;
    @(negedge clk);  // c1
    exc_opcode = 1'b0;
    @(negedge clk);  // c2
    @(negedge clk);  // c3
    reset = 1'b0;
    #1;
    chk("rst stall", 32'(stall[0]), 32'h0);
    chk("rst mux_sel", 32'(mux_sel[0]), 32'h1);
    chk("rst cause", 32'(exc_cause[0]), 32'h0);
    seen = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen |= pc_wr[0];
    end
    chk("rst no pc_wr", 32'(seen), 32'h0);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset        = ($urandom_range(0, 499) != 0);
      ctrl_mux_sel = 4'($urandom_range(0, 15));
      exc_opcode   = ($urandom_range(0, 9) == 0);
      exc_overflow = ($urandom_range(0, 7) == 0);
      exc_div0     = ($urandom_range(0, 7) == 0);
      pc_in        = $urandom;
      mem_rdata    = $urandom;
    end
    reset = 1'b1;
    settle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
